// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
//   Instruction fetch queue between IF and ID. IF pushes {pc, inst} pairs
//   and ID receives them in the same order. When ID stalls, the queue
//   absorbs the pairs and pushes back on IF through inReady. A flush, raised
//   on a jump or an exception, drops every queued entry and also the push
//   presented in the same cycle.
//
// Ports
//   clk       in   1     rising-edge clock
//   rst       in   1     asynchronous reset, active-high
//   inValid   in   1     IF presents a fetched instruction
//   inPc      in   32    pc of the presented instruction
//   inInst    in   32    instruction word from ROM
//   inReady   out  1     buffer can accept a push this cycle
//   flush     in   1     redirect: drop all contents
//   outValid  out  1     head entry valid for ID
//   outPc     out  32    pc of head entry (0 when empty)
//   outInst   out  32    instruction of head entry (0 / NOP when empty)
//   outReady  in   1     ID consumes head this cycle
//   count     out  AW+1  current occupancy, 0..DEPTH
//
// Handshake
//   A transfer happens on a rising edge where valid and ready are both high
//   and flush is low. ready never depends combinationally on the other
//   side's valid or ready. inReady and outValid are derived only from the
//   registered occupancy. A full buffer refuses a push even if a pop happens
//   in the same cycle. Once the producer raises valid, it holds valid and
//   its data until the transfer takes place.
// ---------------------------------------------------------------------------
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inValid,
    input  logic [31:0]   inPc,
    input  logic [31:0]   inInst,
    output logic          inReady,
    input  logic          flush,
    output logic          outValid,
    output logic [31:0]   outPc,
    output logic [31:0]   outInst,
    input  logic          outReady,
    output logic [AW:0]   count
);

    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];

    logic push;
    logic pop;

    assign inReady  = (count_q != CNT_FULL);
    assign outValid = (count_q != '0);
    assign count    = count_q;

    // flush gates both transfers, so it takes priority over push and pop.
    assign push = inValid & inReady & ~flush;
    assign pop  = outValid & outReady & ~flush;

    // Pointers and occupancy. The pointers wrap naturally because
    // DEPTH == 2**AW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset. Only entries between rd_ptr and wr_ptr are
    // ever visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= inPc;
            mem_inst[wr_ptr] <= inInst;
        end
    end

    // First-word fall-through. The head is read straight from storage and
    // forced to zero (a NOP) while the buffer is empty.
    always_comb begin
        outPc   = 32'h0;
        outInst = 32'h0;
        if (outValid) begin
            outPc   = mem_pc[rd_ptr];
            outInst = mem_inst[rd_ptr];
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_fetch_buffer
//   Directed bench for fetch_buffer. Inputs change 1 ns after each rising
//   edge. Outputs are checked at that same point, which shows the state
//   after the edge.
// ---------------------------------------------------------------------------
module tb_fetch_buffer;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic [31:0] inPc;
    logic [31:0] inInst;
    logic        inReady;
    logic        flush;
    logic        outValid;
    logic [31:0] outPc;
    logic [31:0] outInst;
    logic        outReady;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_buffer #(.DEPTH(4), .AW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .inValid  (inValid),
        .inPc     (inPc),
        .inInst   (inInst),
        .inReady  (inReady),
        .flush    (flush),
        .outValid (outValid),
        .outPc    (outPc),
        .outInst  (outInst),
        .outReady (outReady),
        .count    (count)
    );

    // Clock: 10 ns period, first rising edge at 5 ns.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The instruction word tied to each pc, so pc and inst pairing is checked.
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks the complete visible state for an expected head pc and occupancy.
    task automatic chk_state(input string tag, input logic [31:0] pc, input int cnt);
        chk({tag, ".count"},    {29'd0, count},    32'(cnt));
        chk({tag, ".outValid"}, {31'd0, outValid}, (cnt != 0) ? 32'd1 : 32'd0);
        chk({tag, ".inReady"},  {31'd0, inReady},  (cnt != 4) ? 32'd1 : 32'd0);
        chk({tag, ".outPc"},    outPc,             (cnt != 0) ? pc : 32'h0);
        chk({tag, ".outInst"},  outInst,           (cnt != 0) ? inst_of(pc) : 32'h0);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        inValid  = v;
        inPc     = pc;
        inInst   = inst_of(pc);
        outReady = rdy;
        flush    = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // 1: reset with random inputs, checked before the first clock edge.
        #1;
        inValid  = 1'($urandom_range(0, 1));
        inPc     = $urandom;
        inInst   = $urandom;
        outReady = 1'($urandom_range(0, 1));
        flush    = 1'($urandom_range(0, 1));
        rst      = 1'b1;
        #1;
        chk_state("reset", 32'h0, 0);
        tick();
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_state("reset_rel", 32'h0, 0);

        // 2: stream pc 0,4,8 with outReady high, so occupancy stays at most 1.
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        tick(); chk_state("stream0", 32'h0, 1);
        drive(1'b1, 32'h4, 1'b1, 1'b0);
        tick(); chk_state("stream4", 32'h4, 1);
        drive(1'b1, 32'h8, 1'b1, 1'b0);
        tick(); chk_state("stream8", 32'h8, 1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick(); chk_state("stream_drain", 32'h0, 0);

        // 3: fill while ID stalls, refuse a push when full, then drain.
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        tick(); chk_state("fill1", 32'h0, 1);
        drive(1'b1, 32'h4, 1'b0, 1'b0);
        tick(); chk_state("fill2", 32'h0, 2);
        drive(1'b1, 32'h8, 1'b0, 1'b0);
        tick(); chk_state("fill3", 32'h0, 3);
        drive(1'b1, 32'hC, 1'b0, 1'b0);
        tick(); chk_state("fill4", 32'h0, 4);
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        tick(); chk_state("full_refuse", 32'h0, 4);
        // The buffer is full and a pop happens: the push is still refused.
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        tick(); chk_state("full_pop", 32'h4, 3);
        tick(); chk_state("accept16", 32'h8, 3);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick(); chk_state("drain12", 32'hC, 2);
        tick(); chk_state("drain16", 32'h10, 1);
        tick(); chk_state("drain_empty", 32'h0, 0);
        // With the buffer empty, outReady must be ignored.
        tick(); chk_state("empty_hold", 32'h0, 0);

        // 4: ten push/pop pairs at occupancy 2 wrap both pointers.
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h104, 1'b0, 1'b0);
        tick(); chk_state("wrap_pre", 32'h100, 2);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h108 + 32'(4 * i), 1'b1, 1'b0);
            tick(); chk_state($sformatf("wrap%0d", i), 32'h104 + 32'(4 * i), 2);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick(); chk_state("wrap_drain1", 32'h12C, 1);
        tick(); chk_state("wrap_drain2", 32'h0, 0);

        // 5: a flush drops the entries and the same-cycle push.
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h14, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h18, 1'b0, 1'b0);
        tick(); chk_state("preflush", 32'h10, 3);
        drive(1'b1, 32'h40, 1'b1, 1'b1);
        tick(); chk_state("flush1", 32'h0, 0);
        drive(1'b1, 32'h44, 1'b1, 1'b1);
        tick(); chk_state("flush2", 32'h0, 0);
        drive(1'b1, 32'h80, 1'b0, 1'b0);
        tick(); chk_state("postflush", 32'h80, 1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick(); chk_state("postflush_pop", 32'h0, 0);

        // 6: an asynchronous reset pulse between edges empties the buffer at once.
        drive(1'b1, 32'h200, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h204, 1'b0, 1'b0);
        tick(); chk_state("prereset", 32'h200, 2);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk_state("async_rst", 32'h0, 0);
        rst = 1'b0;
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        tick(); chk_state("after_rst", 32'h0, 1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
